// File: rtl/mem_req_bridge.sv
// mem_req_bridge: turns the core's single-cycle memory port into a valid/ready bus
// transaction. The core is stalled until the request completes. Every transaction
// is bounded by a timeout that ends it with a bus error.
module mem_req_bridge #(
    parameter int unsigned                 C_DATA_WIDTH   = 32,
    parameter int unsigned                 TIMEOUT_CYCLES = 256,
    parameter logic [C_DATA_WIDTH-1:0]     ERR_DATA       = C_DATA_WIDTH'(32'hDEADBEEF)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    core_req,
    input  logic                    core_we,
    input  logic [C_DATA_WIDTH-1:0] core_addr,
    input  logic [C_DATA_WIDTH-1:0] core_wdata,
    output logic [C_DATA_WIDTH-1:0] core_rdata,
    output logic                    core_done,
    output logic                    core_stall,
    output logic                    bus_err,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    mem_we,
    output logic [C_DATA_WIDTH-1:0] mem_addr,
    output logic [C_DATA_WIDTH-1:0] mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [C_DATA_WIDTH-1:0] mem_rdata
);

    // The counter only has to reach TIMEOUT_CYCLES-1; a zero setting disables the check.
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic             accept;
    logic             misaligned;
    logic             timeout;
    logic             rd_capture;

    // Done and valid are pure state decodes, so reset removes them immediately.
    assign mem_valid   = (state == REQ);
    assign core_done   = (state == RESP);
    assign core_stall  = core_req & ~core_done;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TO_LAST));

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle strobes; the timeout takes priority over
    // a handshake or response arriving in the same cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        misaligned = 1'b0;
        timeout    = 1'b0;
        rd_capture = 1'b0;
        case (state)
            IDLE: begin
                if (core_req) begin
                    accept = 1'b1;
                    if (core_addr[1:0] != 2'b00) begin
                        misaligned = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (timeout_hit) begin
                    timeout    = 1'b1;
                    state_next = RESP;
                end else if (mem_ready) begin
                    state_next = mem_we ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (timeout_hit) begin
                    timeout    = 1'b1;
                    state_next = RESP;
                end else if (mem_rvalid) begin
                    rd_capture = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Timeout counter: cleared on entry to REQ, counts every REQ/WAIT cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (accept && !misaligned) begin
            cnt <= '0;
        end else if (state == REQ || state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Request registers, loaded once per accepted core request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            mem_we    <= core_we;
            mem_addr  <= {core_addr[C_DATA_WIDTH-1:2], 2'b00};
            mem_wdata <= core_wdata;
        end
    end

    // Sticky error: cleared by an accepted request unless that request is itself misaligned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_err <= 1'b0;
        end else if (accept) begin
            bus_err <= misaligned;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end
    end

    // Read data holds the last read outcome; writes never touch it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_rdata <= '0;
        end else if (rd_capture) begin
            core_rdata <= mem_rdata;
        end else if ((timeout && !mem_we) || (misaligned && !core_we)) begin
            core_rdata <= ERR_DATA;
        end
    end

endmodule
